// File: rtl/pc_stack.sv
// Program counter with a bounded hardware return stack.
// Supports jump, relative branch, call/return and increment, with sticky overflow and underflow flags.
module pc_stack #(
   parameter int              AW       = 8,
   parameter int              DEPTH    = 4,
   parameter logic [AW-1:0]   RST_ADDR = '0,
   localparam int             DW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          freeze,
   input  logic          jump,
   input  logic [AW-1:0] jmpaddr,
   input  logic          branch,
   input  logic [AW-1:0] offset,
   input  logic          call,
   input  logic          ret,
   output logic [AW-1:0] data,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] data_q,  data_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q,   ovf_d;
   logic          unf_q,   unf_d;

   logic [AW-1:0] stack_mem [DEPTH];

   logic          push_en;
   logic [IW-1:0] push_idx;
   logic [AW-1:0] push_val;
   logic [DW-1:0] depth_dec;
   logic [IW-1:0] pop_idx;
   logic          is_full;
   logic          is_empty;

   assign is_full   = (depth_q == DW'(DEPTH));
   assign is_empty  = (depth_q == '0);
   assign depth_dec = depth_q - DW'(1);
   assign pop_idx   = depth_dec[IW-1:0];
   assign push_idx  = depth_q[IW-1:0];
   assign push_val  = data_q + AW'(1);

   // Priority chain: reset, ret, call, jump, branch, increment -- one action per cycle.
   always_comb begin
      data_d  = data_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (reset) begin
         data_d  = RST_ADDR;
         depth_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (ret) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else begin
            data_d  = stack_mem[pop_idx];
            depth_d = depth_dec;
         end
      end else if (call) begin
         if (is_full) begin
            ovf_d = 1'b1;
         end else begin
            push_en = 1'b1;
            data_d  = jmpaddr;
            depth_d = depth_q + DW'(1);
         end
      end else if (jump) begin
         data_d = jmpaddr;
      end else if (branch) begin
         data_d = data_q + offset;
      end else if (!freeze) begin
         data_d = data_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      data_q  <= data_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
   end

   // Stack storage is never reset; depth alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= push_val;
      end
   end

   assign data  = data_q;
   assign depth = depth_q;
   assign full  = is_full;
   assign empty = is_empty;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Randomized and directed checks of pc_stack against a queue-based reference model.
module tb_pc_stack;

   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset, freeze, jump, branch, call, ret;
   logic [AW-1:0] jmpaddr, offset;
   logic [AW-1:0] data;
   logic [2:0]    depth;
   logic          full, empty, ovf, unf;

   int n_cmp = 0;
   int n_err = 0;

   int m_data;
   int m_stk[$];
   bit m_ovf, m_unf;

   pc_stack #(.AW(AW), .DEPTH(DEPTH), .RST_ADDR(8'h00)) dut (
      .clk(clk), .reset(reset), .freeze(freeze), .jump(jump), .jmpaddr(jmpaddr),
      .branch(branch), .offset(offset), .call(call), .ret(ret),
      .data(data), .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_step();
      if (reset) begin
         m_data = 0;
         m_stk.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (ret) begin
         if (m_stk.size() == 0) m_unf = 1;
         else m_data = m_stk.pop_back();
      end else if (call) begin
         if (m_stk.size() == DEPTH) m_ovf = 1;
         else begin
            m_stk.push_back((m_data + 1) % 256);
            m_data = int'(jmpaddr);
         end
      end else if (jump) begin
         m_data = int'(jmpaddr);
      end else if (branch) begin
         m_data = (m_data + int'(offset)) % 256;
      end else if (!freeze) begin
         m_data = (m_data + 1) % 256;
      end
   endfunction

   task automatic drive(input bit rs, input bit fz, input bit jp, input bit br,
                        input bit cl, input bit rt, input logic [7:0] ja, input logic [7:0] of);
      reset = rs; freeze = fz; jump = jp; branch = br; call = cl; ret = rt;
      jmpaddr = ja; offset = of;
      @(posedge clk);
      model_step();
      @(negedge clk);
      $display("txn rst=%0b frz=%0b jmp=%0b br=%0b call=%0b ret=%0b ja=%02h off=%02h -> data=%02h depth=%0d ovf=%0b unf=%0b",
               rs, fz, jp, br, cl, rt, ja, of, data, depth, ovf, unf);
      chk("data",  32'(data),  32'(m_data));
      chk("depth", 32'(depth), 32'(m_stk.size()));
      chk("full",  32'(full),  32'(m_stk.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_stk.size() == 0));
      chk("ovf",   32'(ovf),   32'(m_ovf));
      chk("unf",   32'(unf),   32'(m_unf));
   endtask

   task automatic idle();      drive(0,0,0,0,0,0,8'h00,8'h00); endtask
   task automatic do_jump(input logic [7:0] a); drive(0,0,1,0,0,0,a,8'h00); endtask
   task automatic do_call(input logic [7:0] a); drive(0,0,0,0,1,0,a,8'h00); endtask
   task automatic do_ret();    drive(0,0,0,0,0,1,8'h00,8'h00); endtask
   task automatic do_reset();  drive(1,0,0,0,0,0,8'h00,8'h00); endtask

   initial begin
      reset = 1'b0; freeze = 1'b0; jump = 1'b0; branch = 1'b0;
      call = 1'b0; ret = 1'b0; jmpaddr = '0; offset = '0;
      m_data = 0; m_ovf = 0; m_unf = 0;
      @(negedge clk);

      // Reset and plain increment
      do_reset();
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_empty", 32'(empty), 32'h1);
      idle(); chk("inc1", 32'(data), 32'h01);
      idle(); chk("inc2", 32'(data), 32'h02);
      idle(); chk("inc3", 32'(data), 32'h03);
      chk("inc_depth", 32'(depth), 32'h0);

      // Increment wrap
      do_jump(8'hFE);
      idle(); chk("wrap_ff", 32'(data), 32'hFF);
      idle(); chk("wrap_00", 32'(data), 32'h00);

      // Call / return
      do_jump(8'h10);
      do_call(8'h40);
      chk("call_data", 32'(data), 32'h40);
      chk("call_depth", 32'(depth), 32'h1);
      idle(); idle();
      do_ret();
      chk("ret_data", 32'(data), 32'h11);
      chk("ret_depth", 32'(depth), 32'h0);

      // Overflow and underflow
      do_jump(8'h20);
      do_call(8'h30); do_call(8'h50); do_call(8'h60); do_call(8'h70);
      chk("ovf_full", 32'(full), 32'h1);
      do_call(8'h80);
      chk("ovf_data", 32'(data), 32'h70);
      chk("ovf_depth", 32'(depth), 32'h4);
      chk("ovf_flag", 32'(ovf), 32'h1);
      do_ret(); chk("pop4", 32'(data), 32'h61);
      do_ret(); chk("pop3", 32'(data), 32'h51);
      do_ret(); chk("pop2", 32'(data), 32'h31);
      do_ret(); chk("pop1", 32'(data), 32'h21);
      do_ret();
      chk("unf_data", 32'(data), 32'h21);
      chk("unf_flag", 32'(unf), 32'h1);

      // Branch and priority
      do_reset();
      do_jump(8'h05);
      drive(0,0,0,1,0,0,8'h00,8'hFB); chk("br_back", 32'(data), 32'h00);
      do_jump(8'hFE);
      drive(0,0,0,1,0,0,8'h00,8'h03); chk("br_fwd", 32'(data), 32'h01);
      drive(0,1,1,1,0,0,8'h9A,8'h10); chk("jmp_over_br", 32'(data), 32'h9A);
      do_call(8'h30);
      drive(0,0,0,0,1,1,8'h77,8'h00);
      chk("retcall_data", 32'(data), 32'h9B);
      chk("retcall_depth", 32'(depth), 32'h0);
      chk("retcall_ovf", 32'(ovf), 32'h0);
      drive(0,1,0,0,0,0,8'h00,8'h00); chk("freeze_hold", 32'(data), 32'h9B);

      // Reset in the middle of stack activity
      do_call(8'h01); do_call(8'h02); do_call(8'h03); do_call(8'h04);
      do_call(8'h05);
      do_ret(); do_ret();
      chk("mid_depth", 32'(depth), 32'h2);
      chk("mid_ovf", 32'(ovf), 32'h1);
      drive(1,0,0,0,1,0,8'h55,8'h00);
      chk("mid_rst_data", 32'(data), 32'h00);
      chk("mid_rst_depth", 32'(depth), 32'h0);
      chk("mid_rst_ovf", 32'(ovf), 32'h0);
      do_ret();
      chk("mid_rst_unf", 32'(unf), 32'h1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0),
               8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter AW, default 8: address width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries; legal range is 2 or more.
REQ-003 Parameter RST_ADDR, default 0: value loaded into data at reset, AW bits wide.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 freeze  in  1  when high, the default increment is suppressed.
REQ-007 jump  in  1  absolute jump to jmpaddr.
REQ-008 jmpaddr  in  AW  target for jump and call.
REQ-009 branch  in  1  relative branch by offset.
REQ-010 offset  in  AW  two's-complement displacement.
REQ-011 call  in  1  push the return address, then jump to jmpaddr.
REQ-012 ret  in  1  pop the stack top into data.
REQ-013 data  out  AW  current program counter, registered.
REQ-014 depth  out  clog2(DEPTH+1)  number of occupied stack entries.
REQ-015 full  out  1  high when depth equals DEPTH (combinational from depth).
REQ-016 empty  out  1  high when depth equals 0 (combinational from depth).
REQ-017 ovf  out  1  sticky flag: a call was attempted while full.
REQ-018 unf  out  1  sticky flag: a ret was attempted while empty.

Function
REQ-019 Exactly one action executes per cycle, in this priority order: reset, ret, call, jump, branch, increment.
REQ-020 Increment: when no control input is high and freeze is 0, data <= data+1, modulo 2^AW.
REQ-021 Freeze gates only the increment.
- With freeze=1 and no control input high, data holds.
- ret, call, jump and branch execute regardless of freeze.
REQ-022 Jump: data <= jmpaddr; the stack is unchanged.
REQ-023 Branch: data <= data+offset, truncated to AW bits (wraps in both directions); the stack is unchanged.
REQ-024 Call when not full:
- stack[depth] <= data+1 (mod 2^AW);
- depth <= depth+1;
- data <= jmpaddr.
REQ-025 Call when full:
- no push; data holds and depth holds;
- ovf <= 1.
REQ-026 Ret when not empty:
- data <= stack[depth-1];
- depth <= depth-1.
REQ-027 Ret when empty:
- data holds and depth holds;
- unf <= 1.
REQ-028 Simultaneous ret and call: ret executes; call is ignored (no push, no flag).
REQ-029 Any lower-priority input asserted together with a higher-priority one has no effect that cycle.
REQ-030 Single-cycle latency for every action: the new data is visible in the cycle after the qualifying edge.
REQ-031 Stack is LIFO. Entries at index depth or above are don't-care and never observable on data.
REQ-032 ovf and unf remain set until reset; no other input clears them.
REQ-033 There are no combinational paths from inputs to outputs.

Reset
REQ-034 On a rising edge with reset=1, regardless of all other inputs:
- data <= RST_ADDR;
- depth <= 0;
- ovf <= 0 and unf <= 0.
REQ-035 Stack contents are not cleared by reset and are not observable after it.
REQ-036 Reset asserted mid-sequence (for example during a call or ret) discards all stack entries; the first post-reset ret sets unf.

Verification (AW=8, DEPTH=4, RST_ADDR=0)
REQ-037 Reset, then 3 idle cycles with freeze=0 -> data=0,1,2,3; depth=0; empty=1.
REQ-038 Increment wrap: starting from data=0xFE, 2 idle cycles -> data=0xFF then 0x00.
REQ-039 Call/return:
- at data=0x10, call with jmpaddr=0x40 -> data=0x40, depth=1;
- 2 increments, then ret -> data=0x11, depth=0.
REQ-040 Overflow:
- 4 calls -> full=1;
- 5th call with jmpaddr=0x80 -> data unchanged, depth=4, ovf=1;
- 4 rets -> data = the 4 pushed return addresses in reverse push order;
- a 5th ret -> data holds, unf=1.
REQ-041 Branch and priority:
- at data=0x05, branch with offset=0xFB -> data=0x00;
- at data=0xFE, branch with offset=0x03 -> data=0x01;
- jump+branch together with freeze=1 -> data=jmpaddr;
- ret+call together -> pop only, depth decrements.
REQ-042 Reset mid-operation:
- with depth=2 and ovf=1, reset=1 together with call=1 -> data=0, depth=0, ovf=0;
- the next ret -> unf=1.
